// File: rtl/mem_defs_pkg.sv
// Shared encodings for the M-stage memory access unit: access formats,
// bus size codes, FSM states and the latched bus request.
package mem_defs_pkg;

  localparam logic [2:0] FC_W  = 3'b000;
  localparam logic [2:0] FC_H  = 3'b001;
  localparam logic [2:0] FC_HU = 3'b010;
  localparam logic [2:0] FC_B  = 3'b011;
  localparam logic [2:0] FC_BU = 3'b100;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [3:0] wstrb;
    logic [1:0] lane;
    logic [2:0] fc;
  } bus_req_t;

  // Unknown format codes are treated as word accesses.
  function automatic logic [1:0] fc_size(input logic [2:0] fc);
    case (fc)
      FC_H, FC_HU: return SZ_H;
      FC_B, FC_BU: return SZ_B;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_rdata_fmt.sv
// Load-data formatter: selects the addressed byte/half lane of the raw bus
// word and sign- or zero-extends it according to the access format.
module mem_rdata_fmt
  import mem_defs_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [2:0]  fc_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = raw_i >> {lane_i, 3'b000};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    data_o = raw_i;
    case (fc_i)
      FC_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      FC_HU:   data_o = {16'h0000, shifted[15:0]};
      FC_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      FC_BU:   data_o = {24'h000000, shifted[7:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: issues one SRAM-like bus transaction per access,
// stalls the pipeline until it completes and drains flushed transactions.
module mem_access_unit
  import mem_defs_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memtoregM,
  input  logic          memwriteM,
  input  logic [2:0]    fcM,
  input  logic [AW-1:0] addrM,
  input  logic [DW-1:0] wdataM,
  input  logic          flushM,
  input  logic          advM,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [3:0]    data_wstrb,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic [DW-1:0] rdataM,
  output logic          stallM,
  output logic          adelM,
  output logic          adesM
);

  logic          mem_op, misalign, access, capture;
  logic [1:0]    size_c;
  logic [3:0]    wstrb_c;
  logic [DW-1:0] wdata_c, fmt_data;
  bus_req_t      req_c, req_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  state_t        state_q, state_d;
  logic          killed_q, killed_d;
  logic [DW-1:0] rdata_q, rdata_d;

  assign mem_op   = memtoregM | memwriteM;
  assign size_c   = fc_size(fcM);
  assign misalign = ((size_c == SZ_H) & addrM[0]) | ((size_c == SZ_W) & (|addrM[1:0]));
  assign access   = mem_op & ~misalign & ~flushM;

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdataM;
    case (size_c)
      SZ_B: begin
        wstrb_c = 4'b0001 << addrM[1:0];
        wdata_c = {4{wdataM[7:0]}};
      end
      SZ_H: begin
        wstrb_c = 4'b0011 << {addrM[1], 1'b0};
        wdata_c = {2{wdataM[15:0]}};
      end
      default: ;
    endcase
    if (!memwriteM) wstrb_c = 4'b0000;
  end

  assign req_c = bus_req_t'{wr: memwriteM, size: size_c, wstrb: wstrb_c,
                            lane: addrM[1:0], fc: fcM};

  // Formatting uses the latched request so a killed-then-replaced M stage cannot disturb it.
  mem_rdata_fmt u_fmt (
    .lane_i (req_q.lane),
    .fc_i   (req_q.fc),
    .raw_i  (data_rdata),
    .data_o (fmt_data)
  );

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    rdata_d  = rdata_q;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        killed_d = 1'b0;
        if (access) begin
          capture = 1'b1;
          state_d = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flushM)       killed_d = 1'b1;
        if (data_addr_ok) state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (flushM) killed_d = 1'b1;
        if (data_data_ok) begin
          if (killed_q | flushM) begin
            killed_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            rdata_d = fmt_data;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (advM | flushM) state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      killed_q <= 1'b0;
      rdata_q  <= '0;
      req_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      rdata_q  <= rdata_d;
      if (capture) begin
        req_q   <= req_c;
        addr_q  <= addrM;
        wdata_q <= wdata_c;
      end
    end
  end

  // In IDLE the bus mirrors the M stage; afterwards it replays the latched request.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = '0;
    data_wstrb = '0;
    data_addr  = '0;
    data_wdata = '0;
    stallM     = 1'b0;
    adelM      = 1'b0;
    adesM      = 1'b0;
    rdataM     = '0;
    if (!rst) begin
      adelM  = memtoregM & misalign;
      adesM  = memwriteM & misalign;
      rdataM = rdata_q;
      if (state_q == ST_IDLE) begin
        data_req   = access;
        stallM     = access;
        data_wr    = req_c.wr;
        data_size  = req_c.size;
        data_wstrb = req_c.wstrb;
        data_addr  = addrM;
        data_wdata = wdata_c;
      end else begin
        data_req   = (state_q == ST_ADDR);
        stallM     = (state_q == ST_DONE) ? 1'b0 : (killed_q ? mem_op : 1'b1);
        data_wr    = req_q.wr;
        data_size  = req_q.size;
        data_wstrb = req_q.wstrb;
        data_addr  = addr_q;
        data_wdata = wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level reference model and a
// per-cycle compare process on the negative clock edge.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        memtoregM, memwriteM, flushM, advM;
  logic [2:0]  fcM;
  logic [31:0] addrM, wdataM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, rdataM;
  logic        stallM, adelM, adesM;

  int n_checks = 0;
  int n_errors = 0;

  logic        mon_on = 1'b0;
  logic        chk_rd = 1'b0;
  logic        tx_active = 1'b0;
  logic        tx_st;
  logic [2:0]  tx_fc;
  logic [31:0] tx_addr, tx_wd;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .memtoregM    (memtoregM),
    .memwriteM    (memwriteM),
    .fcM          (fcM),
    .addrM        (addrM),
    .wdataM       (wdataM),
    .flushM       (flushM),
    .advM         (advM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .rdataM       (rdataM),
    .stallM       (stallM),
    .adelM        (adelM),
    .adesM        (adesM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes per access, then lane arithmetic.
  function automatic int nb(input logic [2:0] fc);
    case (fc)
      3'b001, 3'b010: return 2;
      3'b011, 3'b100: return 1;
      default:        return 4;
    endcase
  endfunction

  function automatic logic mis_model(input logic [2:0] fc, input logic [31:0] addr);
    return (int'(addr[1:0]) % nb(fc)) != 0;
  endfunction

  function automatic logic [1:0] exp_size(input logic [2:0] fc);
    int n = nb(fc);
    return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] exp_strb(input logic st, input logic [2:0] fc, input logic [31:0] addr);
    int n = nb(fc);
    int a = int'(addr[1:0]);
    logic [3:0] s = 4'b0000;
    if (!st) return s;
    for (int i = 0; i < 4; i++)
      if (i >= a && i < a + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] fc, input logic [31:0] w);
    int n = nb(fc);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] fc, input logic [31:0] addr, input logic [31:0] raw);
    logic [7:0]  b [4];
    logic [31:0] v;
    int a = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) b[i] = raw[8*i +: 8];
    v = raw;
    if (nb(fc) == 2) begin
      v = {16'h0000, b[a+1], b[a]};
      if (fc == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
    end else if (nb(fc) == 1) begin
      v = {24'h000000, b[a]};
      if (fc == 3'b011 && v[7]) v[31:8] = 24'hFFFFFF;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && mon_on) begin
      check("adelM", {31'b0, adelM}, {31'b0, memtoregM && mis_model(fcM, addrM)});
      check("adesM", {31'b0, adesM}, {31'b0, memwriteM && mis_model(fcM, addrM)});
      if (tx_active && data_req) begin
        check("bus_addr",  data_addr, tx_addr);
        check("bus_wr",    {31'b0, data_wr}, {31'b0, tx_st});
        check("bus_size",  {30'b0, data_size}, {30'b0, exp_size(tx_fc)});
        check("bus_wstrb", {28'b0, data_wstrb}, {28'b0, exp_strb(tx_st, tx_fc, tx_addr)});
        if (tx_st) check("bus_wdata", data_wdata, exp_wdata(tx_fc, tx_wd));
      end
      if (chk_rd) check("rdataM", rdataM, exp_rdata);
    end
  end

  // One access: addr_ok arrives ad cycles after issue, data_ok dd cycles after addr_ok,
  // DONE is held for 'hold' cycles before advM. lit_* are hand-computed expectations.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] fc,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] raw,
                         input int ad, input int dd, input int hold,
                         input logic [1:0] lit_size, input logic [3:0] lit_strb,
                         input logic [31:0] lit_data);
    int req_cnt = 0;
    int stall_cnt = 0;
    memtoregM = ld; memwriteM = st; fcM = fc; addrM = addr; wdataM = wd;
    flushM = 1'b0; advM = 1'b0;
    tx_st = st; tx_fc = fc; tx_addr = addr; tx_wd = wd; tx_active = 1'b1;
    for (int k = 0; k <= ad + dd; k++) begin
      data_addr_ok = (k == ad);
      data_data_ok = (k == ad + dd);
      data_rdata   = (k == ad + dd) ? raw : 32'h5A5A_5A5A;
      @(negedge clk);
      if (k == 0) begin
        check("lit_size", {30'b0, data_size}, {30'b0, lit_size});
        check("lit_wstrb", {28'b0, data_wstrb}, {28'b0, lit_strb});
        if (st) check("lit_wdata", data_wdata, lit_data);
      end
      if (data_req) req_cnt++;
      if (stallM) stall_cnt++;
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    tx_active = 1'b0;
    if (ld) begin
      exp_rdata = exp_load(fc, addr, raw);
      chk_rd = 1'b1;
    end
    check("req_cycles", req_cnt, ad + 1);
    check("stall_cycles", stall_cnt, ad + dd + 1);
    for (int h = 0; h <= hold; h++) begin
      advM = (h == hold);
      @(negedge clk);
      check("done_stall", {31'b0, stallM}, 32'h0);
      check("done_req", {31'b0, data_req}, 32'h0);
      if (ld) check("lit_rdata", rdataM, lit_data);
      @(posedge clk); #1;
    end
    advM = 1'b0; memtoregM = 1'b0; memwriteM = 1'b0; chk_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    memtoregM = 1'b1; memwriteM = 1'b0; fcM = 3'b000; addrM = 32'h1000;
    wdataM = 32'h0; flushM = 1'b0; advM = 1'b0;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #12;
    check("rst_req",   {31'b0, data_req}, 32'h0);
    check("rst_stall", {31'b0, stallM}, 32'h0);
    check("rst_rdata", rdataM, 32'h0);
    addrM = 32'h1002;
    #1;
    check("rst_adel", {31'b0, adelM}, 32'h0);
    memtoregM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mon_on = 1'b1;
    @(posedge clk); #1;

    // LW, addr_ok with req, data_ok two cycles later
    run_txn(1, 0, 3'b000, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 2'd2, 4'b0000, 32'hDEAD_BEEF);

    // LW killed in ADDR: req held until addr_ok, data_ok absorbed, result dropped
    memtoregM = 1'b1; memwriteM = 1'b0; fcM = 3'b000; addrM = 32'h1000;
    tx_st = 1'b0; tx_fc = 3'b000; tx_addr = 32'h1000; tx_wd = 32'h0; tx_active = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      flushM       = (k == 1);
      data_addr_ok = (k == 3);
      data_data_ok = (k == 5);
      data_rdata   = (k == 5) ? 32'h1111_2222 : 32'h0;
      if (k == 2) begin memtoregM = 1'b0; addrM = 32'h0000_BAD0; end
      if (k == 4) begin memtoregM = 1'b1; addrM = 32'h3000; end
      if (k == 6) memtoregM = 1'b0;
      @(negedge clk);
      if (k >= 1 && k <= 3) check("flush_req_held", {31'b0, data_req}, 32'h1);
      if (k == 2 || k == 3) check("killed_stall", {31'b0, stallM}, 32'h0);
      if (k == 4 || k == 5) begin
        check("drain_stall", {31'b0, stallM}, 32'h1);
        check("drain_noreq", {31'b0, data_req}, 32'h0);
      end
      if (k == 6) begin
        check("kill_idle_req", {31'b0, data_req}, 32'h0);
        check("kill_idle_stall", {31'b0, stallM}, 32'h0);
        check("kill_rdata", rdataM, 32'hDEAD_BEEF);
      end
      @(posedge clk); #1;
    end
    tx_active = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

    run_txn(1, 0, 3'b000, 32'h3000, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 2'd2, 4'b0000, 32'hCAFE_F00D);
    run_txn(1, 0, 3'b011, 32'h1003, 32'h0, 32'h80FF_0000, 1, 1, 0, 2'd0, 4'b0000, 32'hFFFF_FF80);
    run_txn(1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF_0000, 0, 3, 0, 2'd0, 4'b0000, 32'h0000_0080);
    run_txn(1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF_0000, 2, 1, 3, 2'd1, 4'b0000, 32'hFFFF_80FF);
    run_txn(1, 0, 3'b010, 32'h1000, 32'h0, 32'h1234_8001, 0, 1, 0, 2'd1, 4'b0000, 32'h0000_8001);
    run_txn(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 1, 0, 2'd1, 4'b1100, 32'hABCD_ABCD);
    run_txn(0, 1, 3'b011, 32'h2001, 32'h1234_ABCD, 32'h0, 0, 1, 0, 2'd0, 4'b0010, 32'hCDCD_CDCD);
    run_txn(0, 1, 3'b000, 32'h2004, 32'hA5A5_0F0F, 32'h0, 4, 1, 0, 2'd2, 4'b1111, 32'hA5A5_0F0F);

    // Misaligned accesses: exception flag only, no request, no stall
    for (int m = 0; m < 4; m++) begin
      memtoregM = (m < 2);
      memwriteM = (m >= 2);
      fcM   = (m == 0 || m == 3) ? 3'b000 : 3'b001;
      addrM = (m == 0) ? 32'h1002 : (m == 1) ? 32'h1001 : (m == 2) ? 32'h2001 : 32'h2003;
      @(negedge clk);
      check("mis_adel", {31'b0, adelM}, (m < 2) ? 32'h1 : 32'h0);
      check("mis_ades", {31'b0, adesM}, (m >= 2) ? 32'h1 : 32'h0);
      check("mis_req", {31'b0, data_req}, 32'h0);
      check("mis_stall", {31'b0, stallM}, 32'h0);
      @(posedge clk); #1;
    end
    memtoregM = 1'b0; memwriteM = 1'b0;

    // Reset while waiting for data_ok
    memtoregM = 1'b1; fcM = 3'b000; addrM = 32'h1000;
    tx_st = 1'b0; tx_fc = 3'b000; tx_addr = 32'h1000; tx_active = 1'b1;
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("pre_rst_req", {31'b0, data_req}, 32'h1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("data_stall", {31'b0, stallM}, 32'h1);
    #1;
    rst = 1'b1; tx_active = 1'b0; exp_rdata = 32'h0;
    #1;
    check("in_rst_req", {31'b0, data_req}, 32'h0);
    check("in_rst_stall", {31'b0, stallM}, 32'h0);
    check("in_rst_rdata", rdataM, 32'h0);
    @(posedge clk); #1;
    memtoregM = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1, 0, 3'b010, 32'h1002, 32'h0, 32'hFEDC_BA98, 1, 2, 1, 2'd1, 4'b0000, 32'h0000_FEDC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
